bus_mem_responder: RTL

Synthesizable responder (slave) end of the MIPS CPU memory bus: address, read, write, waitrequest, writedata, byteenable, readdata. It owns one word-addressed memory window, inserts fixed or pseudo-random wait states, and completes each transfer with a single-cycle waitrequest-low acknowledge. It replaces behavioural bench RAM in FPGA and soak builds, and one instance is placed per memory region (program ROM/RAM, stack).

---
 rtl/bus_mem_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : bus_mem_responder
//  Purpose  : Responder end of the CPU memory bus. Owns one word-addressed
//             memory window, inserts fixed or LFSR-driven wait states and
//             completes each transfer with a single-cycle acknowledge
//             (waitrequest low).
//  Revision : 1.0  initial release
// ============================================================================
module bus_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int          WORDS       = 4096,
    parameter string       INIT_FILE   = "",
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 2,
    parameter int          MAX_WAIT    = 6,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err,
    output logic [15:0] txn_count
);

    localparam int          c_AW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [15:0] c_SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [32:0] c_BASE     = {1'b0, BASE_ADDR};
    // Window limit kept at 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] c_LIMIT    = c_BASE + 33'(4 * WORDS);
    localparam logic [7:0]  c_FIX_WAIT = 8'(WAIT_CYCLES);
    localparam logic [7:0]  c_RND_MOD  = 8'(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_mem [0:WORDS-1];
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_rd;
    logic              r_wr;
    logic              r_ok;
    logic [c_AW-1:0]   r_idx;
    logic [7:0]        r_cnt;
    logic [15:0]       r_lfsr;
    logic              r_err;
    logic [15:0]       r_txn;

    logic [32:0]       w_off;
    logic [c_AW-1:0]   w_idx;
    logic              w_in_range;
    logic              w_req;
    logic              w_access_ok;
    logic [7:0]        w_wait_n;
    logic              w_abort;
    logic              w_lfsr_fb;
    logic              w_accept;

    assign w_off       = {1'b0, address} - c_BASE;
    assign w_idx       = c_AW'(w_off >> 2);
    // Misaligned addresses decode as out of range.
    assign w_in_range  = ({1'b0, address} >= c_BASE) && ({1'b0, address} < c_LIMIT)
                         && (address[1:0] == 2'b00);
    assign w_req       = read | write;
    // A simultaneous read+write request never touches memory.
    assign w_access_ok = w_in_range && !(read && write);
    assign w_wait_n    = (WAIT_MODE == 1) ? (r_lfsr[7:0] % c_RND_MOD) : c_FIX_WAIT;
    assign w_abort     = (r_rd && !read) || (r_wr && !write) || (address != r_addr);
    assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_accept    = (r_state == S_IDLE) && w_req;

    assign err       = r_err;
    assign txn_count = r_txn;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; waitrequest drops only in the acknowledge cycle.
    always_comb begin
        w_state_nxt = r_state;
        waitrequest = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = (w_wait_n != 8'd0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt <= 8'd1) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                waitrequest = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the transfer context on acceptance and count down wait states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_ok    <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_addr  <= address;
            r_wdata <= writedata;
            r_be    <= byteenable;
            r_rd    <= read;
            r_wr    <= write;
            r_ok    <= w_access_ok;
            r_idx   <= w_idx;
            r_cnt   <= w_wait_n;
        end else if (r_state == S_WAIT) begin
            r_cnt   <= r_cnt - 8'd1;
        end
    end

    // Free-running Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= c_SEED;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // Sticky error flag and completed-transfer counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
            r_txn <= '0;
        end else begin
            if (w_accept && !w_access_ok) begin
                r_err <= 1'b1;
            end
            if ((r_state == S_WAIT) && w_abort) begin
                r_err <= 1'b1;
            end
            if (r_state == S_ACK) begin
                r_txn <= r_txn + 16'd1;
            end
        end
    end

    // Byte-lane write commit on the edge that ends a write acknowledge.
    always_ff @(posedge clk) begin
        if ((r_state == S_ACK) && r_wr && r_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is presented only during a valid read acknowledge.
    always_comb begin
        readdata = 32'h0000_0000;
        if ((r_state == S_ACK) && r_rd && r_ok) begin
            readdata = r_mem[r_idx];
        end
    end

endmodule
`default_nettype wire
